reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_if.sv | 28 ++
 rtl/reg_file.sv | 50 +++++
 tb/tb_reg_file.sv | 131 +++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
// Bus bundle for reg_file: two combinational read ports, one write port,
// a reserve port for scoreboarding, and the stall/pending status back out.
interface reg_file_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5
);
  logic [AW-1:0]      RA1;
  logic [AW-1:0]      RA2;
  logic [WIDTH-1:0]   RD1;
  logic [WIDTH-1:0]   RD2;
  logic               WE;
  logic [AW-1:0]      WA;
  logic [WIDTH-1:0]   WD;
  logic               RSV;
  logic [AW-1:0]      RSV_A;
  logic               STALL;
  logic [(2**AW)-1:0] PEND;

  modport master (
    output RA1, RA2, WE, WA, WD, RSV, RSV_A,
    input  RD1, RD2, STALL, PEND
  );

  modport slave (
    input  RA1, RA2, WE, WA, WD, RSV, RSV_A,
    output RD1, RD2, STALL, PEND
  );
endinterface

// File: rtl/reg_file.sv
// 2**AW x WIDTH register file with write-through bypass and a per-register
// pending scoreboard that raises STALL when a read hits an outstanding write.
module reg_file #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic     clk,
  input  logic     reset_n,
  reg_file_if.slave bus
);
  localparam int unsigned NREG = 2**AW;

  logic [WIDTH-1:0] regs_q [NREG];
  logic [NREG-1:0]  pend_q;
  logic [NREG-1:0]  pend_d;
  logic             wr_en;
  logic             rsv_en;
  logic             byp1;
  logic             byp2;

  always_comb begin
    wr_en  = bus.WE  && (bus.WA    != '0);
    rsv_en = bus.RSV && (bus.RSV_A != '0);
    byp1   = wr_en && (bus.WA == bus.RA1);
    byp2   = wr_en && (bus.WA == bus.RA2);
    // Reserve is applied after the write-clear so a same-address collision stays pending.
    pend_d = pend_q;
    if (wr_en)  pend_d[bus.WA]    = 1'b0;
    if (rsv_en) pend_d[bus.RSV_A] = 1'b1;
  end

  // Register 0 is only ever loaded by reset, so it reads as zero without a mux.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q <= '{default: '0};
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
      if (wr_en) regs_q[bus.WA] <= bus.WD;
    end
  end

  always_comb begin
    bus.RD1   = byp1 ? bus.WD : regs_q[bus.RA1];
    bus.RD2   = byp2 ? bus.WD : regs_q[bus.RA2];
    bus.STALL = (pend_q[bus.RA1] && (bus.RA1 != '0) && !byp1)
             || (pend_q[bus.RA2] && (bus.RA2 != '0) && !byp2);
    bus.PEND  = pend_q;
  end
endmodule

// File: tb/tb_reg_file.sv
// Directed vector bench for reg_file: table of one-cycle vectors checked
// before each rising edge, plus hand sequences around asynchronous reset.
module tb_reg_file;
  logic clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_miss = 0;

  reg_file_if #(.WIDTH(32), .AW(5)) bus ();

  reg_file #(.WIDTH(32), .AW(5)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rsv;
    logic [4:0]  rsva;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        stall;
    logic [31:0] pend;
  } vec_t;

  vec_t vt[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic rsv, input logic [4:0] rsva,
                       input logic [4:0] ra1, input logic [4:0] ra2);
    bus.WE = we; bus.WA = wa; bus.WD = wd;
    bus.RSV = rsv; bus.RSV_A = rsva;
    bus.RA1 = ra1; bus.RA2 = ra2;
  endtask

  initial begin
    // we wa wd rsv rsva ra1 ra2 | rd1 rd2 stall pend   (checked before the edge)
    vt[0]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  5'd0,  5'd0,  32'h00000000, 32'h00000000, 1'b0, 32'h00000000};
    vt[1]  = '{1'b0, 5'd0,  32'h00000000, 1'b0, 5'd0,  5'd0,  5'd0,  32'h00000000, 32'h00000000, 1'b0, 32'h00000000};
    vt[2]  = '{1'b1, 5'd5,  32'hAAAAAAAA, 1'b0, 5'd0,  5'd5,  5'd0,  32'hAAAAAAAA, 32'h00000000, 1'b0, 32'h00000000};
    vt[3]  = '{1'b1, 5'd6,  32'h55555555, 1'b0, 5'd0,  5'd5,  5'd6,  32'hAAAAAAAA, 32'h55555555, 1'b0, 32'h00000000};
    vt[4]  = '{1'b0, 5'd0,  32'h00000000, 1'b0, 5'd0,  5'd5,  5'd6,  32'hAAAAAAAA, 32'h55555555, 1'b0, 32'h00000000};
    vt[5]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 1'b0, 5'd0,  5'd7,  5'd5,  32'hA5A5A5A5, 32'hAAAAAAAA, 1'b0, 32'h00000000};
    vt[6]  = '{1'b0, 5'd0,  32'h00000000, 1'b0, 5'd0,  5'd7,  5'd0,  32'hA5A5A5A5, 32'h00000000, 1'b0, 32'h00000000};
    vt[7]  = '{1'b0, 5'd0,  32'h00000000, 1'b1, 5'd9,  5'd0,  5'd0,  32'h00000000, 32'h00000000, 1'b0, 32'h00000000};
    vt[8]  = '{1'b0, 5'd0,  32'h00000000, 1'b0, 5'd0,  5'd0,  5'd9,  32'h00000000, 32'h00000000, 1'b1, 32'h00000200};
    vt[9]  = '{1'b1, 5'd9,  32'hDDDDDDDD, 1'b0, 5'd0,  5'd0,  5'd9,  32'h00000000, 32'hDDDDDDDD, 1'b0, 32'h00000200};
    vt[10] = '{1'b0, 5'd0,  32'h00000000, 1'b0, 5'd0,  5'd0,  5'd9,  32'h00000000, 32'hDDDDDDDD, 1'b0, 32'h00000000};
    vt[11] = '{1'b1, 5'd3,  32'h12345678, 1'b1, 5'd3,  5'd3,  5'd0,  32'h12345678, 32'h00000000, 1'b0, 32'h00000000};
    vt[12] = '{1'b0, 5'd0,  32'h00000000, 1'b0, 5'd0,  5'd3,  5'd0,  32'h12345678, 32'h00000000, 1'b1, 32'h00000008};
    vt[13] = '{1'b0, 5'd0,  32'h00000000, 1'b1, 5'd0,  5'd0,  5'd0,  32'h00000000, 32'h00000000, 1'b0, 32'h00000008};
    vt[14] = '{1'b0, 5'd0,  32'h00000000, 1'b1, 5'd3,  5'd0,  5'd3,  32'h00000000, 32'h12345678, 1'b1, 32'h00000008};
    vt[15] = '{1'b0, 5'd0,  32'h00000000, 1'b0, 5'd0,  5'd0,  5'd3,  32'h00000000, 32'h12345678, 1'b1, 32'h00000008};
    vt[16] = '{1'b1, 5'd3,  32'h0000FFFF, 1'b0, 5'd0,  5'd3,  5'd3,  32'h0000FFFF, 32'h0000FFFF, 1'b0, 32'h00000008};
    vt[17] = '{1'b0, 5'd0,  32'h00000000, 1'b0, 5'd0,  5'd3,  5'd0,  32'h0000FFFF, 32'h00000000, 1'b0, 32'h00000000};
    vt[18] = '{1'b1, 5'd31, 32'h80000001, 1'b1, 5'd31, 5'd31, 5'd31, 32'h80000001, 32'h80000001, 1'b0, 32'h00000000};
    vt[19] = '{1'b0, 5'd0,  32'h00000000, 1'b1, 5'd9,  5'd31, 5'd0,  32'h80000001, 32'h00000000, 1'b1, 32'h80000000};

    reset_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6);
    #3;
    chk("rst.rd1",   bus.RD1, 32'h0);
    chk("rst.rd2",   bus.RD2, 32'h0);
    chk("rst.pend",  bus.PEND, 32'h0);
    chk("rst.stall", {31'b0, bus.STALL}, 32'h0);

    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(vt[i].we, vt[i].wa, vt[i].wd, vt[i].rsv, vt[i].rsva, vt[i].ra1, vt[i].ra2);
      #2;
      chk($sformatf("v%0d.rd1", i),   bus.RD1, vt[i].rd1);
      chk($sformatf("v%0d.rd2", i),   bus.RD2, vt[i].rd2);
      chk($sformatf("v%0d.stall", i), {31'b0, bus.STALL}, {31'b0, vt[i].stall});
      chk($sformatf("v%0d.pend", i),  bus.PEND, vt[i].pend);
    end

    // Asynchronous reset between edges with state outstanding.
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd9);
    #1;
    chk("pre.rd1",   bus.RD1, 32'hAAAAAAAA);
    chk("pre.pend",  bus.PEND, 32'h80000200);
    chk("pre.stall", {31'b0, bus.STALL}, 32'h1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst.pend",  bus.PEND, 32'h0);
    chk("arst.rd1",   bus.RD1, 32'h0);
    chk("arst.rd2",   bus.RD2, 32'h0);
    chk("arst.stall", {31'b0, bus.STALL}, 32'h0);

    // Edges while held in reset must not write or reserve.
    drive(1'b1, 5'd5, 32'h00000001, 1'b1, 5'd4, 5'd6, 5'd0);
    @(posedge clk);
    #1;
    chk("hold.pend", bus.PEND, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
    #1;
    chk("hold.rd1", bus.RD1, 32'h0);

    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 5'd6, 32'hCAFE0001, 1'b0, 5'd0, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd6, 5'd5);
    #1;
    chk("first.rd1", bus.RD1, 32'hCAFE0001);
    chk("first.rd2", bus.RD2, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
